sine_seq_ctrl: RTL and testbench

Sequencer for the sine-sample ROM used by the tone datapath. It generates ROM addresses at a programmable sample rate with a programmable phase step. It fetches each sample over a one-cycle-latency ROM port and presents it to the downstream consumer (PWM/DAC path) over a valid/ready handshake. It runs either for a fixed number of waveform periods or continuously until stopped.

---
 rtl/sine_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sine_seq_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_seq_ctrl.sv
// sine_seq_ctrl: paces sine-ROM fetches at a programmable sample rate
// and hands each sample to the PWM/DAC path over valid/ready.
module sine_seq_ctrl #(
   parameter int N_SAMPLES = 30,
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 16,
   parameter int DIV_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic [DIV_W-1:0]  period_div,
   input  logic [ADDR_W-1:0] step,
   input  logic [7:0]        cycles,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_rd,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] smpl,
   output logic              smpl_vld,
   input  logic              smpl_rdy,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      FETCH,
      LOAD,
      PRESENT
   } state_t;

   localparam logic [DIV_W-1:0]  P_MIN = DIV_W'(3);
   localparam logic [ADDR_W:0]   N_W   = (ADDR_W+1)'(N_SAMPLES);
   localparam logic [ADDR_W-1:0] S_MAX = ADDR_W'(N_SAMPLES-1);

   state_t state, state_nx;

   logic [DIV_W-1:0]  per_q;
   logic [DIV_W-1:0]  tcnt;
   logic [ADDR_W-1:0] step_q;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        cyc_q;
   logic [7:0]        wrap_cnt;
   logic [DATA_W-1:0] smpl_q;
   logic              done_q;
   logic              ovr_q;

   logic              busy_w;
   logic              tick;
   logic              accept;
   logic              abort;
   logic              xfer;
   logic              wrap;
   logic              last;
   logic              miss;
   logic [ADDR_W:0]   sum;
   logic [ADDR_W-1:0] addr_nx;
   logic [DIV_W-1:0]  per_cl;
   logic [ADDR_W-1:0] step_cl;

   assign busy_w = (state != IDLE);
   assign tick   = busy_w && (tcnt == '0);
   assign accept = (state == IDLE) && start && !stop;
   assign abort  = busy_w && stop;
   assign xfer   = (state == PRESENT) && smpl_rdy;

   assign sum     = {1'b0, addr} + {1'b0, step_q};
   assign wrap    = (sum >= N_W);
   assign addr_nx = wrap ? ADDR_W'(sum - N_W) : sum[ADDR_W-1:0];
   assign last    = wrap && (cyc_q != 8'd0)
                    && ((wrap_cnt + 8'd1) == cyc_q);

   // A tick is only lost while a sample is still in flight or unconsumed;
   // a tick coinciding with the transfer starts the next fetch directly.
   assign miss = tick && !stop
                 && ((state == FETCH) || (state == LOAD)
                 || ((state == PRESENT) && !smpl_rdy));

   assign per_cl = (period_div < P_MIN) ? P_MIN : period_div;

   always_comb begin
      step_cl = step;
      unique case (1'b1)
         (step == '0):          step_cl = ADDR_W'(1);
         ({1'b0, step} >= N_W): step_cl = S_MAX;
         default: ;
      endcase
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = WAIT;
         WAIT:    if (tick) state_nx = FETCH;
         FETCH:   state_nx = LOAD;
         LOAD:    state_nx = PRESENT;
         PRESENT: begin
            if (smpl_rdy) begin
               if (last)      state_nx = IDLE;
               else if (tick) state_nx = FETCH;
               else           state_nx = WAIT;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (abort) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_q    <= '0;
         tcnt     <= '0;
         step_q   <= '0;
         addr     <= '0;
         cyc_q    <= '0;
         wrap_cnt <= '0;
         smpl_q   <= '0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            per_q    <= per_cl;
            step_q   <= step_cl;
            cyc_q    <= cycles;
            addr     <= '0;
            wrap_cnt <= '0;
            ovr_q    <= 1'b0;
            tcnt     <= per_cl - DIV_W'(1);
         end else if (busy_w) begin
            tcnt <= tick ? per_q - DIV_W'(1) : tcnt - DIV_W'(1);
            if (miss) ovr_q <= 1'b1;
            if (abort) begin
               done_q <= 1'b1;
            end else begin
               if (state == LOAD) smpl_q <= rom_data;
               if (xfer) begin
                  addr <= addr_nx;
                  if (wrap) wrap_cnt <= wrap_cnt + 8'd1;
                  if (last) done_q <= 1'b1;
               end
            end
         end
      end
   end

   assign rom_addr = addr;
   assign rom_rd   = (state == FETCH);
   assign smpl     = smpl_q;
   assign smpl_vld = (state == PRESENT);
   assign busy     = busy_w;
   assign done     = done_q;
   assign overrun  = ovr_q;

endmodule

// File: tb/tb_sine_seq_ctrl.sv
// Bench for sine_seq_ctrl: timing-arithmetic reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_sine_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] period_div = '0;
   logic [4:0]  step = '0;
   logic [7:0]  cycles = '0;
   logic [4:0]  rom_addr;
   logic        rom_rd;
   logic [15:0] rom_data = '0;
   logic [15:0] smpl;
   logic        smpl_vld;
   logic        smpl_rdy = 1'b1;
   logic        busy;
   logic        done;
   logic        overrun;

   sine_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .period_div(period_div), .step(step), .cycles(cycles),
      .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
      .smpl(smpl), .smpl_vld(smpl_vld), .smpl_rdy(smpl_rdy),
      .busy(busy), .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rom_val(input int a);
      return 16'(a);
   endfunction

   // one-cycle-latency ROM; garbage when not read
   always @(posedge clk)
      rom_data <= rom_rd ? rom_val(int'(rom_addr)) : 16'hDEAD;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   // ---- reference model: ticks from edge arithmetic, not a counter
   int          ecount = 0;
   bit          m_busy = 0, m_vld = 0, m_done = 0, m_ovr = 0;
   int          m_addr = 0, m_wraps = 0, m_P = 3, m_step = 1;
   int          m_cyc = 0, m_t0 = 0, m_rd = -1;
   logic [15:0] m_smpl = '0;

   initial begin
      int  e, c, nxt;
      bit  tk, xf, fetching;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_busy = 0; m_vld = 0; m_done = 0; m_ovr = 0;
            m_addr = 0; m_rd = -1; m_smpl = '0;
         end else begin
            ecount++;
            e = ecount;
            c = e - 1;
            tk = m_busy && (((c - m_t0) % m_P) == m_P - 1);
            m_done = 0;
            if (!m_busy) begin
               if (start && !stop) begin
                  m_P = (period_div < 3) ? 3 : int'(period_div);
                  m_step = int'(step);
                  if (m_step == 0) m_step = 1;
                  else if (m_step >= 30) m_step = 29;
                  m_cyc = int'(cycles);
                  m_t0 = e; m_addr = 0; m_wraps = 0; m_ovr = 0;
                  m_busy = 1; m_vld = 0; m_rd = -1;
               end
            end else if (stop) begin
               m_busy = 0; m_vld = 0; m_rd = -1; m_done = 1;
            end else begin
               xf = m_vld && smpl_rdy;
               fetching = !m_vld && (m_rd >= 0);
               if (tk && (fetching || (m_vld && !xf))) m_ovr = 1;
               if (fetching && e == m_rd + 2) begin
                  m_vld = 1; m_smpl = rom_val(m_addr); m_rd = -1;
               end else if (!m_vld && m_rd < 0 && tk) begin
                  m_rd = e;
               end else if (xf) begin
                  m_vld = 0;
                  nxt = m_addr + m_step;
                  if (nxt >= 30) begin
                     nxt -= 30;
                     m_wraps++;
                     if (m_cyc != 0 && m_wraps == m_cyc) begin
                        m_busy = 0; m_done = 1;
                     end
                  end
                  m_addr = nxt;
                  if (m_busy && tk) m_rd = e;
               end
            end
         end
      end
   end

   // ---- per-cycle compare and logging
   bit chk_en = 0;
   int rd_q[$], rde_q[$], xf_q[$];
   int done_n = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         logic exp_rd;
         exp_rd = m_busy && (m_rd == ecount);
         check("rom_rd", 32'(rom_rd), 32'(exp_rd));
         if (exp_rd) check("rom_addr", 32'(rom_addr), 32'(m_addr));
         check("smpl_vld", 32'(smpl_vld), 32'(m_vld));
         check("smpl", 32'(smpl), 32'(m_smpl));
         check("busy", 32'(busy), 32'(m_busy));
         check("done", 32'(done), 32'(m_done));
         check("overrun", 32'(overrun), 32'(m_ovr));
         if (rom_rd) begin
            rd_q.push_back(int'(rom_addr));
            rde_q.push_back(ecount);
         end
         if (smpl_vld && smpl_rdy) xf_q.push_back(int'(smpl));
         if (done) done_n++;
      end
   end

   // ---- stimulus helpers (all drive at posedge+2)
   int t_start = 0;

   task automatic go(input logic [15:0] p, input logic [4:0] s,
                     input logic [7:0] c);
      @(posedge clk); #2;
      rd_q.delete(); rde_q.delete(); xf_q.delete(); done_n = 0;
      period_div = p; step = s; cycles = c; start = 1'b1;
      @(posedge clk); #2;
      t_start = ecount;
      start = 1'b0;
   endtask

   task automatic wait_rd(input int n, input int budget, input string nm);
      for (int i = 0; i < budget && rd_q.size() < n; i++) begin
         @(posedge clk); #2;
      end
      check(nm, 32'(rd_q.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input int budget, input string nm);
      for (int i = 0; i < budget && busy; i++) begin
         @(posedge clk); #2;
      end
      check(nm, 32'(busy), 32'd0);
      repeat (2) begin @(posedge clk); #2; end
   endtask

   task automatic stop_now();
      stop = 1'b1;
      @(posedge clk); #2;
      stop = 1'b0;
   endtask

   function automatic int spacing_bad(input int p);
      int b;
      b = 0;
      if (rde_q.size() == 0 || rde_q[0] - t_start != p) b++;
      for (int i = 1; i < rde_q.size(); i++)
         if (rde_q[i] - rde_q[i-1] != p) b++;
      return b;
   endfunction

   initial begin
      int bad, n;
      int expb[9] = '{0, 7, 14, 21, 28, 5, 12, 19, 26};

      repeat (2) @(posedge clk);
      #2 chk_en = 1;
      check("rst_busy", 32'(busy), 0);
      check("rst_vld", 32'(smpl_vld), 0);
      check("rst_rd", 32'(rom_rd), 0);
      check("rst_smpl", 32'(smpl), 0);
      check("rst_ovr", 32'(overrun), 0);
      rst_n = 1'b1;

      // A: P=3 step=1 one period
      go(16'd3, 5'd1, 8'd1);
      wait_idle(200, "A_timeout");
      check("A_nxf", 32'(xf_q.size()), 30);
      bad = 0;
      for (int i = 0; i < xf_q.size(); i++) if (xf_q[i] != i) bad++;
      check("A_vals", 32'(bad), 0);
      check("A_spacing", 32'(spacing_bad(3)), 0);
      check("A_done_n", 32'(done_n), 1);
      check("A_ovr", 32'(overrun), 0);
      check("A_smpl_hold", 32'(smpl), 29);

      // B: P=5 step=7 two periods
      go(16'd5, 5'd7, 8'd2);
      wait_idle(300, "B_timeout");
      check("B_nrd", 32'(rd_q.size()), 9);
      bad = 0;
      for (int i = 0; i < 9 && i < rd_q.size(); i++)
         if (rd_q[i] != expb[i]) bad++;
      check("B_addrs", 32'(bad), 0);
      bad = 0;
      foreach (rd_q[i]) if (rd_q[i] == 3) bad++;
      check("B_no_addr3", 32'(bad), 0);
      check("B_done_n", 32'(done_n), 1);

      // C: backpressure on sample 2
      go(16'd4, 5'd1, 8'd0);
      wait_rd(3, 100, "C_reach2");
      smpl_rdy = 1'b0;
      repeat (11) begin @(posedge clk); #2; end
      check("C_hold_val", 32'(smpl), 2);
      check("C_hold_vld", 32'(smpl_vld), 1);
      check("C_ovr", 32'(overrun), 1);
      check("C_no_rd", 32'(rd_q.size()), 3);
      smpl_rdy = 1'b1;
      wait_rd(4, 50, "C_resume");
      check("C_next_addr", 32'((rd_q.size() > 3) ? rd_q[3] : -1), 3);
      stop_now();
      wait_idle(10, "C_stop");
      check("C_ovr_sticky", 32'(overrun), 1);

      // D: clamps
      go(16'd1, 5'd1, 8'd0);
      wait_rd(4, 100, "D1_rd");
      stop_now();
      wait_idle(10, "D1_stop");
      check("D1_spacing", 32'(spacing_bad(3)), 0);
      go(16'd3, 5'd0, 8'd0);
      wait_rd(3, 100, "D2_rd");
      stop_now();
      wait_idle(10, "D2_stop");
      check("D2_seq", 32'((rd_q[0] == 0) && (rd_q[1] == 1)
                          && (rd_q[2] == 2)), 1);
      go(16'd3, 5'd31, 8'd0);
      wait_rd(3, 100, "D3_rd");
      stop_now();
      wait_idle(10, "D3_stop");
      check("D3_seq", 32'((rd_q[0] == 0) && (rd_q[1] == 29)
                          && (rd_q[2] == 28)), 1);

      // E: continuous, ignored restarts, stop after 50 transfers
      go(16'd3, 5'd1, 8'd0);
      n = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #2;
         start = 1'b0;
         n++;
         if (xf_q.size() >= 50) break;
         if (n == 20 || n == 40) begin
            period_div = 16'd7; step = 5'd5; cycles = 8'd1;
            start = 1'b1;
         end
      end
      start = 1'b0;
      check("E_reach50", 32'(xf_q.size() >= 50), 1);
      bad = 0;
      for (int i = 0; i < 50 && i < xf_q.size(); i++)
         if (xf_q[i] != i % 30) bad++;
      check("E_vals", 32'(bad), 0);
      stop_now();
      check("E_busy", 32'(busy), 0);
      check("E_vld", 32'(smpl_vld), 0);
      check("E_done", 32'(done), 1);
      @(posedge clk); #2;
      check("E_done_off", 32'(done), 0);

      // F: async reset mid-sample, then fresh run
      go(16'd3, 5'd1, 8'd0);
      for (int i = 0; i < 100 && !(smpl_vld && smpl != 0); i++) begin
         @(posedge clk); #2;
      end
      check("F_vld_before", 32'(smpl_vld), 1);
      rst_n = 1'b0;
      #1;
      check("F_busy", 32'(busy), 0);
      check("F_vld", 32'(smpl_vld), 0);
      check("F_smpl", 32'(smpl), 0);
      check("F_rd", 32'(rom_rd), 0);
      check("F_addr", 32'(rom_addr), 0);
      check("F_done", 32'(done), 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      go(16'd3, 5'd2, 8'd0);
      wait_rd(2, 50, "F_rd");
      stop_now();
      wait_idle(10, "F_stop");
      check("F_fresh", 32'((rd_q[0] == 0) && (rd_q[1] == 2)), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
